// File: rtl/pc88_loader_sink.sv
// pc88_loader_sink: commits loader bytes to SDRAM via an arbiter write port; optional LDR_CHECKSUM_EN adds ldr_sum
module pc88_loader_sink #(
  parameter int               AW      = 19,
  parameter int               MAW     = 22,
  parameter logic [MAW-1:0]   BASE    = '0,
  parameter int               TIMEOUT = 1023
) (
  input  logic           clk21m,
  input  logic           rstn,
  input  logic [AW-1:0]  ldr_adr,
  input  logic [7:0]     ldr_wdat,
  input  logic           ldr_oe,
  input  logic           ldr_wr,
  output logic           ldr_ack,
  output logic           mem_req,
  output logic [MAW-2:0] mem_adr,
  output logic [15:0]    mem_wdat,
  output logic [1:0]     mem_be,
  input  logic           mem_ack,
  output logic           ldr_busy,
  output logic [AW:0]    ldr_count,
`ifdef LDR_CHECKSUM_EN
  output logic [15:0]    ldr_sum,
`endif
  output logic           ldr_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, ACKH} state_t;
  state_t         r_state, w_next;
  logic           r_oe_d;
  logic [TW-1:0]  r_tmo;
  logic [MAW-1:0] r_badr;
  logic [7:0]     r_dat;
  logic [AW:0]    r_count;
  logic           r_err;
  logic           w_rise, w_done, w_tout, w_take;
  assign w_rise = ldr_oe & ~r_oe_d;
  assign w_done = (r_state == REQ) & mem_ack;
  assign w_tout = (r_state == REQ) & ~mem_ack & (r_tmo == TW'(TIMEOUT - 1));
  assign w_take = (r_state == IDLE) & ldr_wr & ldr_oe;
  assign mem_req   = r_state == REQ;
  assign ldr_ack   = r_state == ACKH;
  assign ldr_busy  = r_state != IDLE;
  assign mem_adr   = r_badr[MAW-1:1];
  assign mem_wdat  = {r_dat, r_dat};
  assign mem_be    = mem_req ? {r_badr[0], ~r_badr[0]} : 2'b00;
  assign ldr_count = r_count;
  assign ldr_err   = r_err;
  // state register
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // next state: IDLE -> REQ (session) or straight to ACKH (no session), ACKH waits for strobe low
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ldr_wr) w_next = ldr_oe ? REQ : ACKH;
      REQ:     if (w_done || w_tout) w_next = ACKH;
      ACKH:    if (!ldr_wr) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // write latch, timeout counter and session statistics; oe rise clears before any same-edge update
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      r_oe_d  <= 1'b0;
      r_tmo   <= '0;
      r_badr  <= '0;
      r_dat   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_oe_d  <= ldr_oe;
      r_tmo   <= (mem_req && !w_done && !w_tout) ? r_tmo + TW'(1) : '0;
      r_badr  <= w_take ? BASE + MAW'(ldr_adr) : r_badr;
      r_dat   <= w_take ? ldr_wdat : r_dat;
      r_count <= (w_rise ? '0 : r_count) + {{AW{1'b0}}, w_done};
      r_err   <= (w_rise ? 1'b0 : r_err) | w_tout;
    end
  end
`ifdef LDR_CHECKSUM_EN
  logic [15:0] r_sum;
  assign ldr_sum = r_sum;
  // running byte sum of committed writes, cleared with the count
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) r_sum <= '0;
    else       r_sum <= (w_rise ? 16'h0 : r_sum) + (w_done ? {8'h0, r_dat} : 16'h0);
  end
`endif
endmodule

// File: tb/tb_pc88_loader_sink.sv
// tb_pc88_loader_sink: directed self-checking bench for pc88_loader_sink
module tb_pc88_loader_sink;
  logic        clk21m = 1'b0, rstn = 1'b0;
  logic [18:0] ldr_adr = '0;
  logic [7:0]  ldr_wdat = '0;
  logic        ldr_oe = 1'b0, ldr_wr = 1'b0, mem_ack = 1'b0;
  logic        ack0, req0, busy0, err0, ack1, req1, busy1, err1;
  logic [20:0] adr0, adr1;
  logic [15:0] wdat0, wdat1;
  logic [1:0]  be0, be1;
  logic [19:0] cnt0, cnt1;
`ifdef LDR_CHECKSUM_EN
  logic [15:0] sum0, sum1;
`endif
  int checks = 0, errors = 0, n;

  always #5 clk21m = ~clk21m;

  pc88_loader_sink #(.BASE(22'h0), .TIMEOUT(15)) u0 (
    .clk21m(clk21m), .rstn(rstn), .ldr_adr(ldr_adr), .ldr_wdat(ldr_wdat), .ldr_oe(ldr_oe),
    .ldr_wr(ldr_wr), .ldr_ack(ack0), .mem_req(req0), .mem_adr(adr0), .mem_wdat(wdat0),
    .mem_be(be0), .mem_ack(mem_ack), .ldr_busy(busy0), .ldr_count(cnt0),
`ifdef LDR_CHECKSUM_EN
    .ldr_sum(sum0),
`endif
    .ldr_err(err0));

  pc88_loader_sink #(.BASE(22'h3FFFFF), .TIMEOUT(15)) u1 (
    .clk21m(clk21m), .rstn(rstn), .ldr_adr(ldr_adr), .ldr_wdat(ldr_wdat), .ldr_oe(ldr_oe),
    .ldr_wr(ldr_wr), .ldr_ack(ack1), .mem_req(req1), .mem_adr(adr1), .mem_wdat(wdat1),
    .mem_be(be1), .mem_ack(mem_ack), .ldr_busy(busy1), .ldr_count(cnt1),
`ifdef LDR_CHECKSUM_EN
    .ldr_sum(sum1),
`endif
    .ldr_err(err1));

  task automatic tick();
    @(posedge clk21m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_req", req0, 0); chk("rst_ack", ack0, 0); chk("rst_busy", busy0, 0);
    chk("rst_cnt", cnt0, 0); chk("rst_err", err0, 0); chk("rst_be", be0, 0);
    rstn = 1'b1;
    tick();
    // single byte, ack after 3 cycles
    ldr_oe = 1'b1; ldr_wr = 1'b1; ldr_adr = 19'h00003; ldr_wdat = 8'hA5;
    tick();
    chk("bw_req", req0, 1); chk("bw_adr", adr0, 21'h000001); chk("bw_be", be0, 2'b10);
    chk("bw_wdat", wdat0, 16'hA5A5); chk("bw_busy", busy0, 1); chk("bw_ack0", ack0, 0);
    ldr_adr = 19'h0; ldr_wdat = 8'h00;
    tick(); tick();
    chk("bw_hold_req", req0, 1); chk("bw_latch_adr", adr0, 21'h000001);
    chk("bw_latch_dat", wdat0, 16'hA5A5); chk("bw_cnt0", cnt0, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("bw_ack", ack0, 1); chk("bw_req_off", req0, 0); chk("bw_cnt", cnt0, 1);
`ifdef LDR_CHECKSUM_EN
    chk("bw_sum", sum0, 16'h00A5);
`endif
    tick();
    chk("bw_ack_held", ack0, 1); chk("bw_cnt_held", cnt0, 1);
    ldr_wr = 1'b0;
    tick();
    chk("bw_ack_drop", ack0, 0); chk("bw_idle", busy0, 0);
    // new session, four back-to-back bytes
    ldr_oe = 1'b0;
    tick();
    ldr_oe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ldr_wr = 1'b1; ldr_adr = 19'(i); ldr_wdat = 8'(8'h11 * (i + 1));
      tick();
      chk("b2b_req", req0, 1); chk("b2b_be", be0, (i % 2) ? 2'b10 : 2'b01);
      chk("b2b_adr", adr0, 21'(i / 2)); chk("b2b_cnt_pre", cnt0, 20'(i));
      mem_ack = 1'b1; ldr_wr = 1'b0;
      tick();
      mem_ack = 1'b0;
      chk("b2b_ack", ack0, 1); chk("b2b_req_off", req0, 0); chk("b2b_cnt", cnt0, 20'(i + 1));
      tick();
      chk("b2b_idle", busy0, 0);
    end
    chk("b2b_total", cnt0, 4);
`ifdef LDR_CHECKSUM_EN
    chk("b2b_sum", sum0, 16'h00AA);
`endif
    // timeout: no mem_ack ever
    ldr_wr = 1'b1; ldr_adr = 19'h5; ldr_wdat = 8'h77;
    tick();
    n = 0;
    while (req0 === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 15); chk("to_ack", ack0, 1); chk("to_err", err0, 1); chk("to_cnt", cnt0, 4);
`ifdef LDR_CHECKSUM_EN
    chk("to_sum", sum0, 16'h00AA);
`endif
    ldr_wr = 1'b0;
    tick();
    chk("to_idle", busy0, 0); chk("to_err_sticky", err0, 1);
    ldr_oe = 1'b0;
    tick();
    ldr_oe = 1'b1;
    tick();
    chk("to_err_clr", err0, 0); chk("to_cnt_clr", cnt0, 0);
    // write with no session active
    ldr_oe = 1'b0; ldr_wr = 1'b1;
    tick();
    chk("oe0_ack", ack0, 1); chk("oe0_req", req0, 0); chk("oe0_cnt", cnt0, 0);
    ldr_wr = 1'b0;
    tick();
    chk("oe0_ack_drop", ack0, 0);
    // address wrap on BASE=0x3FFFFF
    ldr_oe = 1'b1; ldr_wr = 1'b1; ldr_adr = 19'h00002; ldr_wdat = 8'h5A;
    tick();
    chk("wrap_adr", adr1, 21'h0); chk("wrap_be", be1, 2'b10);
    chk("nowrap_adr", adr0, 21'h1); chk("nowrap_be", be0, 2'b01);
    mem_ack = 1'b1; ldr_wr = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("wrap_cnt", cnt1, 1);
    tick();
    // asynchronous reset while in REQ
    ldr_wr = 1'b1; ldr_adr = 19'h7;
    tick();
    chk("ar_req_pre", req0, 1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_req", req0, 0); chk("ar_ack", ack0, 0); chk("ar_busy", busy0, 0);
    ldr_wr = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("ar_idle", busy0, 0); chk("ar_req_post", req0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
